// File: rtl/inv_round_stage.sv
`default_nettype none
//============================================================================
// Module   : inv_round_stage
// Purpose  : One pipelined AES-128 inverse-cipher round. Consumes the
//            round-r state and round key K_r, produces the round-(r-1) state
//            (InvShiftRows -> InvSubBytes -> AddRoundKey(K_{r-1}) ->
//            InvMixColumns, the last step skipped when r == 1) together
//            with K_{r-1} and r-1. A valid/ready handshake is used on both
//            sides with one clock of latency.
// Ports    : clk        clock
//            rst        asynchronous active-low reset
//            in_valid   / in_ready   upstream handshake
//            state,key,num           round-r state, K_r, r (legal 1..10)
//            done       / out_ready  downstream handshake
//            state_out,key_out,num_out  round-(r-1) state, K_{r-1}, r-1
// Build    : INV_ROUND_SKID_EN defined -> two-entry buffer, in_ready driven
//            from a register only. Undefined -> single output register,
//            in_ready = !done | out_ready.
// Revision : 1.0 - initial release
//============================================================================
module inv_round_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state,
    input  logic [127:0] key,
    input  logic [3:0]   num,
    output logic         done,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic [127:0] key_out,
    output logic [3:0]   num_out
);

    // ---------------- GF(2^8) arithmetic, polynomial 0x11b ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p1, p2, p3, p4, p5, p6, p7;
        p1 = xtime(a);  p2 = xtime(p1); p3 = xtime(p2); p4 = xtime(p3);
        p5 = xtime(p4); p6 = xtime(p5); p7 = xtime(p6);
        return ({8{b[0]}} & a)  ^ ({8{b[1]}} & p1) ^ ({8{b[2]}} & p2) ^
               ({8{b[3]}} & p3) ^ ({8{b[4]}} & p4) ^ ({8{b[5]}} & p5) ^
               ({8{b[6]}} & p6) ^ ({8{b[7]}} & p7);
    endfunction

    // a^254 = a^-1 for a != 0, and 0 -> 0 falls out naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a4, a8, a16, a32, a64, a128;
        a2  = gf_mul(a, a);     a4  = gf_mul(a2, a2);   a8   = gf_mul(a4, a4);
        a16 = gf_mul(a8, a8);   a32 = gf_mul(a16, a16); a64  = gf_mul(a32, a32);
        a128 = gf_mul(a64, a64);
        return gf_mul(gf_mul(gf_mul(a2, a4), gf_mul(a8, a16)),
                      gf_mul(gf_mul(a32, a64), a128));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
               {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // ---------------- Round datapath (input -> registers only) -------------
    logic         w_legal;
    logic [31:0]  w_kw0, w_kw1, w_kw2, w_kw3, w_rot;
    logic [127:0] w_prev_key, w_isb, w_ark, w_imc;
    logic [127:0] w_res_state, w_res_key;
    logic [3:0]   w_res_num;

    assign w_legal = (num != 4'd0) && (num <= 4'd10);

    // Undo one key-expansion step; w3' must be formed first because the
    // SubWord term is taken from the recovered w3 of K_{r-1}.
    assign w_kw3 = key[31:0]  ^ key[63:32];
    assign w_kw2 = key[63:32] ^ key[95:64];
    assign w_kw1 = key[95:64] ^ key[127:96];
    assign w_rot = {w_kw3[23:0], w_kw3[31:24]};
    assign w_kw0 = key[127:96] ^
                   {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])} ^
                   {rcon(num), 24'h000000};
    assign w_prev_key = {w_kw0, w_kw1, w_kw2, w_kw3};

    // InvShiftRows folded into the InvSubBytes byte routing: output byte
    // (row, col) is taken from input byte (row, col - row mod 4).
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        localparam int ROW = gi % 4;
        localparam int COL = gi / 4;
        localparam int SRC = 4 * ((COL + 4 - ROW) % 4) + ROW;
        assign w_isb[127-8*gi -: 8] = inv_sbox(state[127-8*SRC -: 8]);
    end

    assign w_ark = w_isb ^ w_prev_key;

    for (genvar gc = 0; gc < 4; gc++) begin : g_col
        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        assign w_a0 = w_ark[127-32*gc -: 8];
        assign w_a1 = w_ark[119-32*gc -: 8];
        assign w_a2 = w_ark[111-32*gc -: 8];
        assign w_a3 = w_ark[103-32*gc -: 8];
        assign w_imc[127-32*gc -: 8] = gf_mul(w_a0, 8'h0e) ^ gf_mul(w_a1, 8'h0b) ^
                                       gf_mul(w_a2, 8'h0d) ^ gf_mul(w_a3, 8'h09);
        assign w_imc[119-32*gc -: 8] = gf_mul(w_a0, 8'h09) ^ gf_mul(w_a1, 8'h0e) ^
                                       gf_mul(w_a2, 8'h0b) ^ gf_mul(w_a3, 8'h0d);
        assign w_imc[111-32*gc -: 8] = gf_mul(w_a0, 8'h0d) ^ gf_mul(w_a1, 8'h09) ^
                                       gf_mul(w_a2, 8'h0e) ^ gf_mul(w_a3, 8'h0b);
        assign w_imc[103-32*gc -: 8] = gf_mul(w_a0, 8'h0b) ^ gf_mul(w_a1, 8'h0d) ^
                                       gf_mul(w_a2, 8'h09) ^ gf_mul(w_a3, 8'h0e);
    end

    // Illegal round numbers pass the beat through untouched.
    assign w_res_state = !w_legal ? state : ((num == 4'd1) ? w_ark : w_imc);
    assign w_res_key   = w_legal ? w_prev_key : key;
    assign w_res_num   = w_legal ? (num - 4'd1) : num;

    // ---------------- Handshake and output registers -----------------------
    logic         done_q, done_d;
    logic [127:0] st_q, st_d, ky_q, ky_d;
    logic [3:0]   nm_q, nm_d;
    logic         w_push, w_pop;

`ifdef INV_ROUND_SKID_EN
    logic         sk_vld_q, sk_vld_d;
    logic [127:0] sk_st_q, sk_st_d, sk_ky_q, sk_ky_d;
    logic [3:0]   sk_nm_q, sk_nm_d;

    // Full only when the skid entry holds a beat; purely registered.
    assign in_ready = rst & ~sk_vld_q;
`else
    assign in_ready = rst & (~done_q | out_ready);
`endif

    assign w_push = in_valid & in_ready;
    assign w_pop  = done_q & out_ready;

    always_comb begin
        done_d = done_q;
        st_d   = st_q;
        ky_d   = ky_q;
        nm_d   = nm_q;
`ifdef INV_ROUND_SKID_EN
        sk_vld_d = sk_vld_q;
        sk_st_d  = sk_st_q;
        sk_ky_d  = sk_ky_q;
        sk_nm_d  = sk_nm_q;
        if (sk_vld_q) begin
            // in_ready is low here, so only the skid-to-main move can happen.
            if (w_pop) begin
                st_d     = sk_st_q;
                ky_d     = sk_ky_q;
                nm_d     = sk_nm_q;
                sk_vld_d = 1'b0;
            end
        end else if (w_push) begin
            if (!done_q || w_pop) begin
                st_d   = w_res_state;
                ky_d   = w_res_key;
                nm_d   = w_res_num;
                done_d = 1'b1;
            end else begin
                sk_st_d  = w_res_state;
                sk_ky_d  = w_res_key;
                sk_nm_d  = w_res_num;
                sk_vld_d = 1'b1;
            end
        end else if (w_pop) begin
            done_d = 1'b0;
        end
`else
        if (w_push) begin
            st_d   = w_res_state;
            ky_d   = w_res_key;
            nm_d   = w_res_num;
            done_d = 1'b1;
        end else if (w_pop) begin
            done_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q   <= 1'b0;
            st_q     <= '0;
            ky_q     <= '0;
            nm_q     <= '0;
`ifdef INV_ROUND_SKID_EN
            sk_vld_q <= 1'b0;
            sk_st_q  <= '0;
            sk_ky_q  <= '0;
            sk_nm_q  <= '0;
`endif
        end else begin
            done_q   <= done_d;
            st_q     <= st_d;
            ky_q     <= ky_d;
            nm_q     <= nm_d;
`ifdef INV_ROUND_SKID_EN
            sk_vld_q <= sk_vld_d;
            sk_st_q  <= sk_st_d;
            sk_ky_q  <= sk_ky_d;
            sk_nm_q  <= sk_nm_d;
`endif
        end
    end

    assign done      = done_q;
    assign state_out = st_q;
    assign key_out   = ky_q;
    assign num_out   = nm_q;

endmodule
`default_nettype wire

// File: tb/tb_inv_round_stage.sv
`default_nettype none
//============================================================================
// Module   : tb_inv_round_stage
// Purpose  : Self-checking bench for inv_round_stage: FIPS-197 vectors,
//            final/illegal rounds, backpressure, async reset, a randomized
//            scoreboard run, and a ten-stage decrypt chain fed with blocks
//            encrypted by a behavioural AES-128 model.
// Revision : 1.0 - initial release
//============================================================================
module tb_inv_round_stage;

    typedef struct packed {
        logic [127:0] s;
        logic [127:0] k;
        logic [3:0]   n;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, out_ready;
    logic [127:0] state, key;
    logic [3:0]   num;
    logic         in_ready, done;
    logic [127:0] state_out, key_out;
    logic [3:0]   num_out;

    inv_round_stage u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .state(state), .key(key), .num(num), .done(done), .out_ready(out_ready),
        .state_out(state_out), .key_out(key_out), .num_out(num_out)
    );

    // Ten-stage decrypt chain.
    logic         t_v, t_rdy;
    logic [127:0] t_s, t_k;
    logic [3:0]   t_n;
    wire          ch_v [0:10];
    wire          ch_r [0:10];
    wire  [127:0] ch_s [0:10];
    wire  [127:0] ch_k [0:10];
    wire  [3:0]   ch_n [0:10];

    assign ch_v[0]  = t_v;
    assign ch_s[0]  = t_s;
    assign ch_k[0]  = t_k;
    assign ch_n[0]  = t_n;
    assign ch_r[10] = t_rdy;

    for (genvar j = 0; j < 10; j++) begin : g_chain
        inv_round_stage u_stage (
            .clk(clk), .rst(rst), .in_valid(ch_v[j]), .in_ready(ch_r[j]),
            .state(ch_s[j]), .key(ch_k[j]), .num(ch_n[j]), .done(ch_v[j+1]),
            .out_ready(ch_r[j+1]), .state_out(ch_s[j+1]), .key_out(ch_k[j+1]),
            .num_out(ch_n[j+1])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- Behavioural AES model ----------------
    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];
    logic [127:0] rkeys [0:10];

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, aa, bb;
        r = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) r = r ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // S-box from the multiplicative group generated by 3: walk p = 3^i
    // alongside q = 3^-i, so q is the inverse of p at every step.
    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01; q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rol8(q, 1) ^ rol8(q, 2) ^ rol8(q, 3) ^ rol8(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic aes_enc(input logic [127:0] pt, output logic [127:0] ct);
        logic [127:0] s, t;
        logic [7:0]   a0, a1, a2, a3;
        s = pt ^ rkeys[0];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[127-8*(4*c+r) -: 8] = sb[s[127-8*(4*((c+r)%4)+r) -: 8]];
            if (rnd < 10) begin
                s = t;
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
                    a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
                    t[127-32*c -: 8] = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                    t[119-32*c -: 8] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                    t[111-32*c -: 8] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                    t[103-32*c -: 8] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                end
            end
            s = t ^ rkeys[rnd];
        end
        ct = s;
    endtask

    task automatic ref_round(input logic [127:0] s, input logic [127:0] k,
                             input logic [3:0] n, output beat_t b);
        logic [31:0]  w0, w1, w2, w3, t;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] pk, x, y;
        if (n < 4'd1 || n > 4'd10) begin
            b.s = s; b.k = k; b.n = n;
            return;
        end
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        w3 = w3 ^ w2; w2 = w2 ^ w1; w1 = w1 ^ w0;
        t  = {w3[23:0], w3[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        rc = 8'h01;
        for (int i = 1; i < int'(n); i++) rc = gm(rc, 8'h02);
        w0 = w0 ^ t ^ {rc, 24'h0};
        pk = {w0, w1, w2, w3};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                x[127-8*(4*c+r) -: 8] = isb[s[127-8*(4*((c-r+4)%4)+r) -: 8]];
        x = x ^ pk;
        for (int c = 0; c < 4; c++) begin
            a0 = x[127-32*c -: 8]; a1 = x[119-32*c -: 8];
            a2 = x[111-32*c -: 8]; a3 = x[103-32*c -: 8];
            y[127-32*c -: 8] = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
            y[119-32*c -: 8] = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
            y[111-32*c -: 8] = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
            y[103-32*c -: 8] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
        end
        b.s = (n == 4'd1) ? x : y;
        b.k = pk;
        b.n = n - 4'd1;
    endtask

    function automatic logic [127:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present one beat with out_ready=1 from an empty/draining stage.
    task automatic one_beat(input logic [127:0] s, input logic [127:0] k, input logic [3:0] n);
        state = s; key = k; num = n; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("beat_done", 128'(done), 128'(1'b1));
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4 && done; i++) begin
            @(posedge clk); #1;
        end
        chk("drain_done", 128'(done), 128'(1'b0));
    endtask

    beat_t        e, e3 [3];
    beat_t        sbq [$];
    logic [127:0] s3 [3], k3 [3];
    logic [127:0] pt [16], ck [16], hs [16], hk [16];
    logic [127:0] ct;
    int           acc, rx, idx, exp_acc;
    logic         push, pop;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        build_tables();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        state = '0; key = '0; num = '0;
        t_v = 1'b0; t_rdy = 1'b0; t_s = '0; t_k = '0; t_n = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done",     128'(done), 128'(1'b0));
        chk("rst_state",    state_out, 128'h0);
        chk("rst_key",      key_out,   128'h0);
        chk("rst_num",      128'(num_out), 128'h0);
        chk("rst_in_ready", 128'(in_ready), 128'(1'b0));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", 128'(in_ready), 128'(1'b1));

        // FIPS-197 C.1 inverse round, num=10
        one_beat(128'h7ad5fda789ef4e272bca100b3d9ff59f, 128'h13111d7fe3944a17f307a78b4d2b30c5, 4'd10);
        chk("fips_state", state_out, 128'h54d990a16ba09ab596bbf40ea111702f);
        chk("fips_key",   key_out,   128'h549932d1f08557681093ed9cbe2c974e);
        chk("fips_num",   128'(num_out), 128'd9);

        // Final round, no InvMixColumns
        one_beat(128'h6353e08c0960e104cd70b751bacad0e7, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe, 4'd1);
        chk("final_state", state_out, 128'h00112233445566778899aabbccddeeff);
        chk("final_key",   key_out,   128'h000102030405060708090a0b0c0d0e0f);
        chk("final_num",   128'(num_out), 128'd0);

        // Illegal round number passes through
        one_beat({16{8'ha5}}, {16{8'ha5}}, 4'd0);
        chk("illegal_state", state_out, {16{8'ha5}});
        chk("illegal_key",   key_out,   {16{8'ha5}});
        chk("illegal_num",   128'(num_out), 128'd0);
        drain();

        // Backpressure: three beats offered while out_ready is low
`ifdef INV_ROUND_SKID_EN
        exp_acc = 2;
`else
        exp_acc = 1;
`endif
        for (int i = 0; i < 3; i++) begin
            s3[i] = r128(); k3[i] = r128();
            ref_round(s3[i], k3[i], 4'(10 - i), e3[i]);
        end
        out_ready = 1'b0; acc = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            in_valid = (acc < 3);
            if (acc < 3) begin state = s3[acc]; key = k3[acc]; num = 4'(10 - acc); end
            #1;
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
            if (acc > 0) begin
                chk("bp_hold_done",  128'(done), 128'(1'b1));
                chk("bp_hold_state", state_out, e3[0].s);
            end
        end
        in_valid = 1'b0;
        chk("bp_accepted", 128'(acc), 128'(exp_acc));
        chk("bp_in_ready_full", 128'(in_ready), 128'(1'b0));
        out_ready = 1'b1; rx = 0;
        for (int cyc = 0; cyc < 20 && rx < 3; cyc++) begin
            in_valid = (acc < 3);
            if (acc < 3) begin state = s3[acc]; key = k3[acc]; num = 4'(10 - acc); end
            #1;
            if (done) begin
                chk("bp_out_state", state_out, e3[rx].s);
                chk("bp_out_key",   key_out,   e3[rx].k);
                chk("bp_out_num",   128'(num_out), 128'(e3[rx].n));
                rx++;
            end
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_rx_count", 128'(rx), 128'd3);
        drain();

        // Asynchronous reset while stalled
        out_ready = 1'b0; state = r128(); key = r128(); num = 4'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst5_stalled", 128'(done), 128'(1'b1));
        #2 rst = 1'b0;
        #1;
        chk("rst5_done",  128'(done), 128'(1'b0));
        chk("rst5_state", state_out, 128'h0);
        chk("rst5_key",   key_out,   128'h0);
        chk("rst5_num",   128'(num_out), 128'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        state = r128(); key = r128();
        ref_round(state, key, 4'd3, e);
        one_beat(state, key, 4'd3);
        chk("rst5_after_state", state_out, e.s);
        chk("rst5_after_key",   key_out,   e.k);
        drain();

        // Randomized scoreboard run
        sbq.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            chk("sb_done", 128'(done), 128'(sbq.size() != 0));
            if (sbq.size() != 0) begin
                chk("sb_state", state_out, sbq[0].s);
                chk("sb_key",   key_out,   sbq[0].k);
                chk("sb_num",   128'(num_out), 128'(sbq[0].n));
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            state     = r128();
            key       = r128();
            num       = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                    : 4'($urandom_range(1, 10));
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
`ifdef INV_ROUND_SKID_EN
            chk("sb_in_ready", 128'(in_ready), 128'(sbq.size() < 2));
`else
            chk("sb_in_ready", 128'(in_ready), 128'((sbq.size() == 0) || out_ready));
`endif
            pop  = done & out_ready;
            push = in_valid & in_ready;
            if (pop && sbq.size() != 0) void'(sbq.pop_front());
            if (push) begin
                ref_round(state, key, num, e);
                sbq.push_back(e);
            end
            @(posedge clk); #1;
        end
        drain();
        drain();

        // Ten-stage chain decrypting model-encrypted blocks
        for (int b = 0; b < 16; b++) begin
            pt[b] = r128(); ck[b] = r128();
            expand(ck[b]);
            aes_enc(pt[b], ct);
            hs[b] = ct ^ rkeys[10];
            hk[b] = rkeys[10];
        end
        idx = 0; rx = 0;
        for (int cyc = 0; cyc < 3000 && rx < 16; cyc++) begin
            t_v = (idx < 16);
            if (idx < 16) begin t_s = hs[idx]; t_k = hk[idx]; t_n = 4'd10; end
            t_rdy = ($urandom_range(0, 3) != 0);
            #1;
            if (t_v && ch_r[0]) idx++;
            if (ch_v[10] && t_rdy) begin
                chk("chain_pt",  ch_s[10], pt[rx]);
                chk("chain_k0",  ch_k[10], ck[rx]);
                chk("chain_num", 128'(ch_n[10]), 128'd0);
                rx++;
            end
            @(posedge clk); #1;
        end
        t_v = 1'b0;
        chk("chain_count", 128'(rx), 128'd16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
